// File: rtl/add_mul_comp_sub_seq.sv
// add_mul_comp_sub_seq: handshaked add/sub/compare (one cycle) and
// iterative shift-add multiply (WIDTH cycles) with registered result.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operation presented        in_ready   ready to accept (IDLE)
//   op         00 add, 01 sub, 10 cmp, 11 mul
//   sgn        compare only: 1 signed, 0 unsigned
//   a, b       WIDTH-bit operands
//   out_valid  result valid (DONE)        out_ready  consumer accepts
//   result     2*WIDTH-bit result, held while out_valid
module add_mul_comp_sub_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_result;

    logic [2*WIDTH-1:0] w_sum;
    logic [2*WIDTH-1:0] w_single;
    logic [WIDTH:0]     w_addx;
    logic [WIDTH:0]     w_subx;
    logic               w_lt;
    logic               w_eq;
    logic               w_gt;
    logic               w_last;
    logic               w_is_mul;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;

    assign w_is_mul = (op == 2'b11);
    assign w_last   = (r_cnt == LAST);

    // One partial product per MUL cycle, multiplier consumed LSB first.
    assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Single-cycle results straight from the inputs on the accept edge.
    always_comb begin
        w_addx = {1'b0, a} + {1'b0, b};
        // Top bit of the widened difference is the unsigned borrow.
        w_subx = {1'b0, a} - {1'b0, b};
        w_eq   = (a == b);
        w_lt   = sgn ? ($signed(a) < $signed(b)) : (a < b);
        w_gt   = !w_lt && !w_eq;
        w_single = '0;
        unique case (op)
            2'b00:   w_single[WIDTH:0] = w_addx;
            2'b01:   w_single[WIDTH:0] = w_subx;
            2'b10:   w_single[2:0]     = {w_gt, w_eq, w_lt};
            default: w_single          = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next = w_is_mul ? MUL : DONE;
                end
            end
            MUL: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_is_mul) begin
                            r_acc    <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, a};
                            r_mplier <= b;
                            r_cnt    <= '0;
                        end else begin
                            r_result <= w_single;
                        end
                    end
                end
                MUL: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    // Last partial product lands straight in the result.
                    if (w_last) begin
                        r_result <= w_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_mul_comp_sub_seq.sv
// Testbench for add_mul_comp_sub_seq: WIDTH=8 and WIDTH=16 instances,
// directed cases plus random ops against an arithmetic reference model.
module tb_add_mul_comp_sub_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv8, ir8, sg8, ov8, or8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;

    logic        iv16, ir16, sg16, ov16, or16;
    logic [1:0]  op16;
    logic [15:0] a16, b16;
    logic [31:0] res16;

    int n_chk  = 0;
    int n_fail = 0;

    add_mul_comp_sub_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .op(op8), .sgn(sg8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .result(res8)
    );

    add_mul_comp_sub_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(iv16), .in_ready(ir16),
        .op(op16), .sgn(sg16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(or16), .result(res16)
    );

    // Reference: plain integer arithmetic on the operation definitions.
    function automatic longint model(input int w, input logic [1:0] op,
                                     input logic sgn,
                                     input longint a, input longint b);
        longint m;
        longint sa;
        longint sb;
        m = longint'(1) << w;
        case (op)
            2'd0: return a + b;
            2'd1: return (a >= b) ? (a - b) : ((a + m - b) + m);
            2'd2: begin
                sa = (sgn && a >= m / 2) ? a - m : a;
                sb = (sgn && b >= m / 2) ? b - m : b;
                if (sa < sb) return 1;
                if (sa == sb) return 2;
                return 4;
            end
            default: return a * b;
        endcase
    endfunction

    // Presents one op, waits for out_valid; lat counts edges from the
    // accept edge inclusive (single-cycle: 1, multiply: WIDTH+1).
    task automatic do_op8(input logic [1:0] op, input logic sgn,
                          input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [15:0] res);
        iv8 = 1'b1; op8 = op; sg8 = sgn; a8 = a; b8 = b;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = res8;
    endtask

    task automatic do_op16(input logic [1:0] op, input logic sgn,
                           input logic [15:0] a, input logic [15:0] b,
                           output int lat, output logic [31:0] res);
        iv16 = 1'b1; op16 = op; sg16 = sgn; a16 = a; b16 = b;
        @(posedge clk); #1;
        iv16 = 1'b0;
        lat = 1;
        while (!ov16 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = res16;
    endtask

    task automatic ack8();
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    task automatic ack16();
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv8 = 1'b1; op8 = 2'b00; sg8 = 1'b0; a8 = 8'd1; b8 = 8'd2;
        iv16 = 1'b1; op16 = 2'b11; sg16 = 1'b0; a16 = 16'd3; b16 = 16'd4;
        or8 = 1'b0; or16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (ir8 !== 1'b1) begin
            n_fail++; $display("FAIL reset_ir8 got %b exp 1", ir8);
        end
        n_chk++;
        if (ov8 !== 1'b0) begin
            n_fail++; $display("FAIL reset_ov8 got %b exp 0", ov8);
        end
        n_chk++;
        if (res8 !== 16'h0000) begin
            n_fail++; $display("FAIL reset_res8 got %h exp 0000", res8);
        end
        n_chk++;
        if (ir16 !== 1'b1) begin
            n_fail++; $display("FAIL reset_ir16 got %b exp 1", ir16);
        end
        n_chk++;
        if (ov16 !== 1'b0) begin
            n_fail++; $display("FAIL reset_ov16 got %b exp 0", ov16);
        end
        n_chk++;
        if (res16 !== 32'h0) begin
            n_fail++; $display("FAIL reset_res16 got %h exp 0", res16);
        end
        iv8 = 1'b0; iv16 = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (ov8 !== 1'b0 || ov16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_accept got ov8=%b ov16=%b exp 0 0",
                     ov8, ov16);
        end
    endtask

    task automatic test_add();
        int lat;
        logic [15:0] res;
        do_op8(2'b00, 1'b0, 8'd200, 8'd100, lat, res);
        n_chk++;
        if (res !== 16'h012C) begin
            n_fail++; $display("FAIL add_res got %h exp 012C", res);
        end
        n_chk++;
        if (lat !== 1) begin
            n_fail++; $display("FAIL add_lat got %0d exp 1", lat);
        end
        n_chk++;
        if (ir8 !== 1'b0) begin
            n_fail++; $display("FAIL add_busy got ir=%b exp 0", ir8);
        end
        ack8();
        n_chk++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
            n_fail++;
            $display("FAIL add_release got ir=%b ov=%b exp 1 0", ir8, ov8);
        end
    endtask

    task automatic test_sub();
        logic [7:0]  ta [2] = '{8'd5, 8'd7};
        logic [7:0]  tb [2] = '{8'd7, 8'd5};
        logic [15:0] te [2] = '{16'h01FE, 16'h0002};
        int lat;
        logic [15:0] res;
        for (int i = 0; i < 2; i++) begin
            do_op8(2'b01, 1'b0, ta[i], tb[i], lat, res);
            n_chk++;
            if (res !== te[i] || lat !== 1) begin
                n_fail++;
                $display("FAIL sub_%0d got %h lat %0d exp %h lat 1",
                         i, res, lat, te[i]);
            end
            ack8();
        end
    endtask

    task automatic test_compare();
        logic [7:0]  ta [3] = '{8'h80, 8'h80, 8'h33};
        logic [7:0]  tb [3] = '{8'h7F, 8'h7F, 8'h33};
        logic        ts [3] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] te [3] = '{16'h0004, 16'h0001, 16'h0002};
        int lat;
        logic [15:0] res;
        for (int i = 0; i < 3; i++) begin
            do_op8(2'b10, ts[i], ta[i], tb[i], lat, res);
            n_chk++;
            if (res !== te[i] || lat !== 1) begin
                n_fail++;
                $display("FAIL cmp_%0d got %h lat %0d exp %h lat 1",
                         i, res, lat, te[i]);
            end
            ack8();
        end
    endtask

    task automatic test_mul8();
        int lat;
        logic [15:0] res;
        do_op8(2'b11, 1'b0, 8'hFF, 8'hFF, lat, res);
        n_chk++;
        if (res !== 16'hFE01) begin
            n_fail++; $display("FAIL mul8_res got %h exp FE01", res);
        end
        n_chk++;
        if (lat !== 9) begin
            n_fail++; $display("FAIL mul8_lat got %0d exp 9", lat);
        end
        ack8();
        do_op8(2'b11, 1'b0, 8'h00, 8'hAB, lat, res);
        n_chk++;
        if (res !== 16'h0000 || lat !== 9) begin
            n_fail++;
            $display("FAIL mul8_zero got %h lat %0d exp 0000 lat 9",
                     res, lat);
        end
        ack8();
    endtask

    task automatic test_mul16();
        int lat;
        logic [31:0] res;
        do_op16(2'b11, 1'b0, 16'h00FF, 16'h00FF, lat, res);
        n_chk++;
        if (res !== 32'h0000FE01 || lat !== 17) begin
            n_fail++;
            $display("FAIL mul16_ff got %h lat %0d exp 0000FE01 lat 17",
                     res, lat);
        end
        ack16();
        do_op16(2'b11, 1'b0, 16'hFFFF, 16'hFFFF, lat, res);
        n_chk++;
        if (res !== 32'hFFFE0001 || lat !== 17) begin
            n_fail++;
            $display("FAIL mul16_max got %h lat %0d exp FFFE0001 lat 17",
                     res, lat);
        end
        ack16();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] res;
        do_op8(2'b00, 1'b0, 8'h11, 8'h22, lat, res);
        n_chk++;
        if (res !== 16'h0033) begin
            n_fail++; $display("FAIL bp_res got %h exp 0033", res);
        end
        iv8 = 1'b1; op8 = 2'b11; a8 = 8'h55; b8 = 8'h66;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_chk++;
            if (ov8 !== 1'b1 || res8 !== 16'h0033 || ir8 !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d got ov=%b res=%h ir=%b exp 1 0033 0",
                         i, ov8, res8, ir8);
            end
        end
        iv8 = 1'b0;
        ack8();
        n_chk++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release got ir=%b ov=%b exp 1 0", ir8, ov8);
        end
        @(posedge clk); #1;
        n_chk++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_ghost got ir=%b ov=%b exp 1 0", ir8, ov8);
        end
    endtask

    task automatic test_reset_mul();
        bit seen;
        iv8 = 1'b1; op8 = 2'b11; sg8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_chk++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1 || res8 !== 16'h0000) begin
            n_fail++;
            $display("FAIL rstmul_state got ov=%b ir=%b res=%h exp 0 1 0000",
                     ov8, ir8, res8);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ov8 !== 1'b0) seen = 1'b1;
        end
        n_chk++;
        if (seen) begin
            n_fail++; $display("FAIL rstmul_late got out_valid pulse exp none");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        longint exp;
        or8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            exp = model(8, 2'b00, 1'b0, longint'(a), longint'(b));
            iv8 = 1'b1; op8 = 2'b00; a8 = a; b8 = b;
            @(posedge clk); #1;
            n_chk++;
            if (ov8 !== 1'b1 || res8 !== exp[15:0]) begin
                n_fail++;
                $display("FAIL b2b_res_%0d got ov=%b res=%h exp 1 %h",
                         i, ov8, res8, exp[15:0]);
            end
            @(posedge clk); #1;
            n_chk++;
            if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_ready_%0d got ir=%b ov=%b exp 1 0",
                         i, ir8, ov8);
            end
        end
        iv8 = 1'b0;
        or8 = 1'b0;
    endtask

    task automatic test_random8();
        logic [1:0]  op;
        logic        sgn;
        logic [7:0]  a;
        logic [7:0]  b;
        longint      exp;
        int          lat;
        int          expl;
        logic [15:0] res;
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            sgn = 1'($urandom);
            a   = 8'($urandom);
            b   = 8'($urandom);
            exp = model(8, op, sgn, longint'(a), longint'(b));
            expl = (op == 2'b11) ? 9 : 1;
            do_op8(op, sgn, a, b, lat, res);
            n_chk++;
            if (res !== exp[15:0] || lat !== expl) begin
                n_fail++;
                $display("FAIL rnd8_%0d op=%0d a=%h b=%h got %h lat %0d exp %h lat %0d",
                         i, op, a, b, res, lat, exp[15:0], expl);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            n_chk++;
            if (ov8 !== 1'b1 || res8 !== exp[15:0]) begin
                n_fail++;
                $display("FAIL rnd8_hold_%0d got ov=%b res=%h exp 1 %h",
                         i, ov8, res8, exp[15:0]);
            end
            ack8();
        end
    endtask

    task automatic test_random16();
        logic [1:0]  op;
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        longint      exp;
        int          lat;
        int          expl;
        logic [31:0] res;
        for (int i = 0; i < 12; i++) begin
            op  = 2'($urandom_range(0, 3));
            sgn = 1'($urandom);
            a   = 16'($urandom);
            b   = 16'($urandom);
            exp = model(16, op, sgn, longint'(a), longint'(b));
            expl = (op == 2'b11) ? 17 : 1;
            do_op16(op, sgn, a, b, lat, res);
            n_chk++;
            if (res !== exp[31:0] || lat !== expl) begin
                n_fail++;
                $display("FAIL rnd16_%0d op=%0d a=%h b=%h got %h lat %0d exp %h lat %0d",
                         i, op, a, b, res, lat, exp[31:0], expl);
            end
            ack16();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_compare();
        test_mul8();
        test_mul16();
        test_backpressure();
        test_reset_mul();
        test_back_to_back();
        test_random8();
        test_random16();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
